// File: rtl/average_unpooling_if.sv
`default_nettype none
// ============================================================================
// Module      : average_unpooling_if
// Description : Job interface for average_unpooling. The master side issues
//               a start request with the pooled map. The slave side returns
//               the reconstructed map and a done flag.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Signals:
//   start        master -> slave  request; only honoured while the block idles
//   input_data   master -> slave  pooled map, element (r,c) at
//                                 [(r*OUTPUT_W+c)*DATA_WIDTH +: DATA_WIDTH]
//   output_data  slave -> master  reconstructed map, element (r,c) at
//                                 [(r*W+c)*DATA_WIDTH +: DATA_WIDTH]
//   done         slave -> master  result valid; held until the next start
// ============================================================================
interface average_unpooling_if #(
  parameter int H          = 3,
  parameter int W          = 4,
  parameter int POOL_SIZE  = 2,
  parameter int S          = 1,
  parameter int OUTPUT_H   = ((H - POOL_SIZE) / S + 1),
  parameter int OUTPUT_W   = ((W - POOL_SIZE) / S + 1),
  parameter int DATA_WIDTH = 8
);
  logic                                       start;
  logic [0:DATA_WIDTH*OUTPUT_H*OUTPUT_W-1]    input_data;
  logic [0:DATA_WIDTH*H*W-1]                  output_data;
  logic                                       done;

  modport master (
    output start,
    output input_data,
    input  output_data,
    input  done
  );

  modport slave (
    input  start,
    input  input_data,
    output output_data,
    output done
  );
endinterface
`default_nettype wire

// File: rtl/average_unpooling.sv
`default_nettype none
// ============================================================================
// Module      : average_unpooling
// Description : Scatters every element of a pooled OUTPUT_H x OUTPUT_W map
//               back over its POOL_SIZE x POOL_SIZE window of an H x W map,
//               accumulating overlaps, then normalizes each pixel.
//               Default build: divide by the number of windows covering the
//               pixel. With macro AVG_UNPOOL_GRAD_EN defined: divide by
//               POOL_SIZE*POOL_SIZE (average-pooling backward pass).
//               Uncovered pixels always produce 0.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk    input   rising-edge clock
//   rst_n  input   synchronous active-low reset
//   bus    slave   start / input_data in, output_data / done out
// Timing: start sampled at edge 0 -> done high after edge
//         OUTPUT_H*OUTPUT_W*POOL_SIZE^2 + H*W + 1.
// ============================================================================
module average_unpooling #(
  parameter int H          = 3,
  parameter int W          = 4,
  parameter int POOL_SIZE  = 2,
  parameter int S          = 1,
  parameter int OUTPUT_H   = ((H - POOL_SIZE) / S + 1),
  parameter int OUTPUT_W   = ((W - POOL_SIZE) / S + 1),
  parameter int DATA_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  average_unpooling_if.slave  bus
);

  localparam int PP      = POOL_SIZE * POOL_SIZE;
  localparam int NIN     = OUTPUT_H * OUTPUT_W;
  localparam int NPIX    = H * W;
  localparam int ACC_W   = DATA_WIDTH + $clog2(PP);
  localparam int CNT_W   = $clog2(PP + 1);
  localparam int OH_W    = (OUTPUT_H > 1) ? $clog2(OUTPUT_H) : 1;
  localparam int OW_W    = (OUTPUT_W > 1) ? $clog2(OUTPUT_W) : 1;
  localparam int PI_W    = (POOL_SIZE > 1) ? $clog2(POOL_SIZE) : 1;
  localparam int IN_W    = (NIN > 1) ? $clog2(NIN) : 1;
  localparam int PIX_W   = (NPIX > 1) ? $clog2(NPIX) : 1;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SCATTER   = 2'd1,
    ST_NORMALIZE = 2'd2,
    ST_COMPLETE  = 2'd3
  } state_t;

  state_t                       state_q;
  logic [0:DATA_WIDTH*NIN-1]    latch_q;
  logic [ACC_W-1:0]             acc_q [NPIX];
  logic [CNT_W-1:0]             cnt_q [NPIX];
  logic [DATA_WIDTH-1:0]        out_q [NPIX];
  logic [OH_W-1:0]              oh_q;
  logic [OW_W-1:0]              ow_q;
  logic [PI_W-1:0]              i_q;
  logic [PI_W-1:0]              j_q;
  logic [PIX_W-1:0]             p_q;
  logic                         done_q;

  logic [DATA_WIDTH-1:0]        in_elem [NIN];
  logic [0:DATA_WIDTH*NPIX-1]   out_packed;
  logic [PIX_W-1:0]             tgt_pix;
  logic [IN_W-1:0]              win_idx;
  logic [ACC_W-1:0]             quot;

  // Unpack the latched pooled map and pack the result registers.
  always_comb begin
    for (int k = 0; k < NIN; k++) begin
      in_elem[k] = latch_q[k*DATA_WIDTH +: DATA_WIDTH];
    end
    out_packed = '0;
    for (int k = 0; k < NPIX; k++) begin
      out_packed[k*DATA_WIDTH +: DATA_WIDTH] = out_q[k];
    end
  end

  assign bus.output_data = out_packed;
  assign bus.done        = done_q;

  // Scatter target: pixel (oh*S+i, ow*S+j) receives pooled element (oh,ow).
  always_comb begin
    tgt_pix = PIX_W'(((int'(oh_q) * S) + int'(i_q)) * W + (int'(ow_q) * S) + int'(j_q));
    win_idx = IN_W'(int'(oh_q) * OUTPUT_W + int'(ow_q));
  end

  // Normalization quotient for pixel p. A zero count means no window reached
  // the pixel; its accumulator is also zero, so both modes return 0 there.
  always_comb begin
    quot = '0;
    if (cnt_q[p_q] != '0) begin
`ifdef AVG_UNPOOL_GRAD_EN
      quot = acc_q[p_q] / ACC_W'(PP);
`else
      quot = acc_q[p_q] / ACC_W'(cnt_q[p_q]);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      latch_q <= '0;
      oh_q    <= '0;
      ow_q    <= '0;
      i_q     <= '0;
      j_q     <= '0;
      p_q     <= '0;
      done_q  <= 1'b0;
      for (int k = 0; k < NPIX; k++) begin
        acc_q[k] <= '0;
        cnt_q[k] <= '0;
        out_q[k] <= '0;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            latch_q <= bus.input_data;
            oh_q    <= '0;
            ow_q    <= '0;
            i_q     <= '0;
            j_q     <= '0;
            p_q     <= '0;
            done_q  <= 1'b0;
            for (int k = 0; k < NPIX; k++) begin
              acc_q[k] <= '0;
              cnt_q[k] <= '0;
            end
            state_q <= ST_SCATTER;
          end
        end

        ST_SCATTER: begin
          acc_q[tgt_pix] <= acc_q[tgt_pix] + ACC_W'(in_elem[win_idx]);
          cnt_q[tgt_pix] <= cnt_q[tgt_pix] + CNT_W'(1);
          // Nested odometer: j fastest, then i, ow, oh.
          if (j_q != PI_W'(POOL_SIZE - 1)) begin
            j_q <= j_q + PI_W'(1);
          end else begin
            j_q <= '0;
            if (i_q != PI_W'(POOL_SIZE - 1)) begin
              i_q <= i_q + PI_W'(1);
            end else begin
              i_q <= '0;
              if (ow_q != OW_W'(OUTPUT_W - 1)) begin
                ow_q <= ow_q + OW_W'(1);
              end else begin
                ow_q <= '0;
                if (oh_q != OH_W'(OUTPUT_H - 1)) begin
                  oh_q <= oh_q + OH_W'(1);
                end else begin
                  oh_q    <= '0;
                  p_q     <= '0;
                  state_q <= ST_NORMALIZE;
                end
              end
            end
          end
        end

        ST_NORMALIZE: begin
          // The quotient is bounded by the largest input, so it fits.
          out_q[p_q] <= DATA_WIDTH'(quot);
          if (p_q != PIX_W'(NPIX - 1)) begin
            p_q <= p_q + PIX_W'(1);
          end else begin
            p_q     <= '0;
            state_q <= ST_COMPLETE;
          end
        end

        ST_COMPLETE: begin
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_average_unpooling.sv
`default_nettype none
// ============================================================================
// Module      : tb_average_unpooling
// Description : Self-checking bench for average_unpooling. Three instances:
//               A = defaults (3x4, P=2, S=1, overlapping windows),
//               B = 4x4, P=2, S=2 (non-overlapping),
//               C = 3x3, P=2, S=2 (row 2 / col 2 uncovered).
//               Expected maps come from a coverage-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_average_unpooling;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  average_unpooling_if #(.H(3), .W(4), .POOL_SIZE(2), .S(1), .DATA_WIDTH(8)) ifa ();
  average_unpooling_if #(.H(4), .W(4), .POOL_SIZE(2), .S(2), .DATA_WIDTH(8)) ifb ();
  average_unpooling_if #(.H(3), .W(3), .POOL_SIZE(2), .S(2), .DATA_WIDTH(8)) ifc ();

  average_unpooling #(.H(3), .W(4), .POOL_SIZE(2), .S(1), .DATA_WIDTH(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa));
  average_unpooling #(.H(4), .W(4), .POOL_SIZE(2), .S(2), .DATA_WIDTH(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb));
  average_unpooling #(.H(3), .W(3), .POOL_SIZE(2), .S(2), .DATA_WIDTH(8)) dut_c (
    .clk(clk), .rst_n(rst_n), .bus(ifc));

  // Reference: for each pixel, sum every pooled value whose window covers it.
  function automatic void model(input int h, input int w, input int p, input int s,
                                input int pooled[$], output int res[$]);
    int ohn, own, sum, n;
    ohn = (h - p) / s + 1;
    own = (w - p) / s + 1;
    res = {};
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        sum = 0;
        n   = 0;
        for (int a = 0; a < ohn; a++) begin
          for (int b = 0; b < own; b++) begin
            if (r >= a*s && r < a*s + p && c >= b*s && c < b*s + p) begin
              sum += pooled[a*own + b];
              n++;
            end
          end
        end
`ifdef AVG_UNPOOL_GRAD_EN
        res.push_back(sum / (p*p));
`else
        res.push_back((n != 0) ? sum / n : 0);
`endif
      end
    end
  endfunction

  function automatic logic [0:255] pack(input int q[$]);
    logic [0:255] v;
    v = '0;
    for (int k = 0; k < q.size(); k++) v[k*8 +: 8] = 8'(q[k]);
    return v;
  endfunction

  function automatic void unpack(input logic [0:255] v, input int n, output int q[$]);
    q = {};
    for (int k = 0; k < n; k++) q.push_back(int'(v[k*8 +: 8]));
  endfunction

  function automatic void rand_map(input int n, output int q[$]);
    q = {};
    for (int k = 0; k < n; k++) q.push_back(int'($urandom_range(0, 255)));
  endfunction

  // Runs one job on instance A. Optionally, at cycle dist_cyc after the start
  // edge, either pulses start with alt data or just swaps input_data to alt.
  task automatic run_a(input int pooled[$], input int dist_cyc, input bit dist_start,
                       input int alt[$], output int got[$], output int lat,
                       output logic done0, output int first_out[$]);
    logic [0:255] t;
    t = pack(pooled);
    ifa.input_data = t[0:47];
    ifa.start = 1'b1;
    @(negedge clk);
    ifa.start = 1'b0;
    done0 = ifa.done;
    t = '0;
    t[0:95] = ifa.output_data;
    unpack(t, 12, first_out);
    lat = 0;
    while (ifa.done !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
      if (dist_cyc != 0 && lat == dist_cyc) begin
        t = pack(alt);
        ifa.input_data = t[0:47];
        if (dist_start) ifa.start = 1'b1;
      end
      if (dist_cyc != 0 && lat == dist_cyc + 1) ifa.start = 1'b0;
    end
    if (lat >= 200) lat = -1;
    t = '0;
    t[0:95] = ifa.output_data;
    unpack(t, 12, got);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ifa.start = 1'b0; ifb.start = 1'b0; ifc.start = 1'b0;
    ifa.input_data = '0; ifb.input_data = '0; ifc.input_data = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (ifa.output_data !== '0 || ifa.done !== 1'b0) begin
      n_bad++; $display("FAIL reset_a: out=%h done=%b required out=0 done=0", ifa.output_data, ifa.done);
    end
    n_cmp++;
    if (ifb.output_data !== '0 || ifb.done !== 1'b0) begin
      n_bad++; $display("FAIL reset_b: out=%h done=%b required out=0 done=0", ifb.output_data, ifb.done);
    end
    n_cmp++;
    if (ifc.output_data !== '0 || ifc.done !== 1'b0) begin
      n_bad++; $display("FAIL reset_c: out=%h done=%b required out=0 done=0", ifc.output_data, ifc.done);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_overlap();
    int pooled[$], exp[$], got[$], fo[$], lat;
    int spot_idx[4], spot_val[4];
    logic d0;
    pooled = {10, 20, 30, 40, 50, 60};
    model(3, 4, 2, 1, pooled, exp);
    run_a(pooled, 0, 1'b0, pooled, got, lat, d0, fo);
    n_cmp++;
    if (lat !== 37) begin n_bad++; $display("FAIL overlap_latency: got %0d required 37", lat); end
    for (int k = 0; k < 12; k++) begin
      n_cmp++;
      if (got[k] !== exp[k]) begin
        n_bad++; $display("FAIL overlap_pix%0d: got %0d required %0d", k, got[k], exp[k]);
      end
    end
    // Hand-derived spot values: pixel indices 0,1,5,11 = (0,0),(0,1),(1,1),(2,3).
    spot_idx = '{0, 1, 5, 11};
`ifdef AVG_UNPOOL_GRAD_EN
    spot_val = '{2, 7, 30, 15};
`else
    spot_val = '{10, 15, 30, 60};
`endif
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (got[spot_idx[k]] !== spot_val[k]) begin
        n_bad++; $display("FAIL overlap_spot%0d: got %0d required %0d", spot_idx[k], got[spot_idx[k]], spot_val[k]);
      end
    end
  endtask

  task automatic test_random();
    int pooled[$], exp[$], got[$], fo[$], lat;
    logic d0;
    for (int it = 0; it < 5; it++) begin
      rand_map(6, pooled);
      model(3, 4, 2, 1, pooled, exp);
      run_a(pooled, 0, 1'b0, pooled, got, lat, d0, fo);
      n_cmp++;
      if (lat !== 37) begin n_bad++; $display("FAIL random%0d_latency: got %0d required 37", it, lat); end
      for (int k = 0; k < 12; k++) begin
        n_cmp++;
        if (got[k] !== exp[k]) begin
          n_bad++; $display("FAIL random%0d_pix%0d: got %0d required %0d", it, k, got[k], exp[k]);
        end
      end
    end
  endtask

  task automatic test_max();
    int pooled[$], exp[$], got[$], fo[$], lat;
    logic d0;
    pooled = {255, 255, 255, 255, 255, 255};
    model(3, 4, 2, 1, pooled, exp);
    run_a(pooled, 0, 1'b0, pooled, got, lat, d0, fo);
    for (int k = 0; k < 12; k++) begin
      n_cmp++;
      if (got[k] !== exp[k]) begin
        n_bad++; $display("FAIL max_pix%0d: got %0d required %0d", k, got[k], exp[k]);
      end
    end
`ifdef AVG_UNPOOL_GRAD_EN
    n_cmp++;
    if (got[0] !== 63 || got[5] !== 255) begin
      n_bad++; $display("FAIL max_spot: got (0,0)=%0d (1,1)=%0d required 63 255", got[0], got[5]);
    end
`else
    n_cmp++;
    if (got[0] !== 255 || got[5] !== 255) begin
      n_bad++; $display("FAIL max_spot: got (0,0)=%0d (1,1)=%0d required 255 255", got[0], got[5]);
    end
`endif
  endtask

  task automatic test_control();
    int pooled[$], alt[$], exp[$], got[$], fo[$], lat;
    logic d0;
    // start pulse with different data mid-scatter must be ignored
    rand_map(6, pooled);
    rand_map(6, alt);
    model(3, 4, 2, 1, pooled, exp);
    run_a(pooled, 5, 1'b1, alt, got, lat, d0, fo);
    n_cmp++;
    if (lat !== 37) begin n_bad++; $display("FAIL ignore_start_latency: got %0d required 37", lat); end
    for (int k = 0; k < 12; k++) begin
      n_cmp++;
      if (got[k] !== exp[k]) begin
        n_bad++; $display("FAIL ignore_start_pix%0d: got %0d required %0d", k, got[k], exp[k]);
      end
    end
    // input_data changed after start: latched data must be used
    rand_map(6, pooled);
    rand_map(6, alt);
    model(3, 4, 2, 1, pooled, exp);
    run_a(pooled, 3, 1'b0, alt, got, lat, d0, fo);
    for (int k = 0; k < 12; k++) begin
      n_cmp++;
      if (got[k] !== exp[k]) begin
        n_bad++; $display("FAIL latched_input_pix%0d: got %0d required %0d", k, got[k], exp[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int p1[$], p2[$], e1[$], e2[$], got[$], fo[$], lat;
    logic d0;
    rand_map(6, p1);
    rand_map(6, p2);
    model(3, 4, 2, 1, p1, e1);
    model(3, 4, 2, 1, p2, e2);
    run_a(p1, 0, 1'b0, p1, got, lat, d0, fo);
    // Second start issued in the cycle done first rises.
    run_a(p2, 0, 1'b0, p2, got, lat, d0, fo);
    n_cmp++;
    if (d0 !== 1'b0) begin n_bad++; $display("FAIL b2b_done_clear: got %b required 0", d0); end
    for (int k = 0; k < 12; k++) begin
      n_cmp++;
      if (fo[k] !== e1[k]) begin
        n_bad++; $display("FAIL b2b_hold_pix%0d: got %0d required %0d", k, fo[k], e1[k]);
      end
    end
    n_cmp++;
    if (lat !== 37) begin n_bad++; $display("FAIL b2b_latency: got %0d required 37", lat); end
    for (int k = 0; k < 12; k++) begin
      n_cmp++;
      if (got[k] !== e2[k]) begin
        n_bad++; $display("FAIL b2b_pix%0d: got %0d required %0d", k, got[k], e2[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int pooled[$], exp[$], got[$], fo[$], lat;
    logic [0:255] t;
    logic d0;
    rand_map(6, pooled);
    t = pack(pooled);
    ifa.input_data = t[0:47];
    ifa.start = 1'b1;
    @(negedge clk);
    ifa.start = 1'b0;
    repeat (29) @(negedge clk);   // now in NORMALIZE
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (ifa.output_data !== '0 || ifa.done !== 1'b0) begin
      n_bad++; $display("FAIL reset_mid: out=%h done=%b required out=0 done=0", ifa.output_data, ifa.done);
    end
    rst_n = 1'b1;
    repeat (45) @(negedge clk);
    n_cmp++;
    if (ifa.done !== 1'b0) begin
      n_bad++; $display("FAIL reset_mid_idle: done=%b required 0", ifa.done);
    end
    rand_map(6, pooled);
    model(3, 4, 2, 1, pooled, exp);
    run_a(pooled, 0, 1'b0, pooled, got, lat, d0, fo);
    n_cmp++;
    if (lat !== 37) begin n_bad++; $display("FAIL post_reset_latency: got %0d required 37", lat); end
    for (int k = 0; k < 12; k++) begin
      n_cmp++;
      if (got[k] !== exp[k]) begin
        n_bad++; $display("FAIL post_reset_pix%0d: got %0d required %0d", k, got[k], exp[k]);
      end
    end
  endtask

  task automatic test_nonoverlap();
    int pooled[$], exp[$], got[$], lat;
    logic [0:255] t;
    for (int it = 0; it < 2; it++) begin
      if (it == 0) pooled = {1, 2, 3, 4};
      else rand_map(4, pooled);
      model(4, 4, 2, 2, pooled, exp);
      t = pack(pooled);
      ifb.input_data = t[0:31];
      ifb.start = 1'b1;
      @(negedge clk);
      ifb.start = 1'b0;
      lat = 0;
      while (ifb.done !== 1'b1 && lat < 200) begin @(negedge clk); lat++; end
      n_cmp++;
      if (lat !== 33) begin n_bad++; $display("FAIL nonoverlap%0d_latency: got %0d required 33", it, lat); end
      t = '0;
      t[0:127] = ifb.output_data;
      unpack(t, 16, got);
      for (int k = 0; k < 16; k++) begin
        n_cmp++;
        if (got[k] !== exp[k]) begin
          n_bad++; $display("FAIL nonoverlap%0d_pix%0d: got %0d required %0d", it, k, got[k], exp[k]);
        end
      end
`ifndef AVG_UNPOOL_GRAD_EN
      if (it == 0) begin
        // Quadrant replication: (0,0)=1, (0,3)=2, (3,0)=3, (3,3)=4.
        n_cmp++;
        if (got[0] !== 1 || got[3] !== 2 || got[12] !== 3 || got[15] !== 4) begin
          n_bad++; $display("FAIL nonoverlap_corners: got %0d %0d %0d %0d required 1 2 3 4",
                            got[0], got[3], got[12], got[15]);
        end
      end
`endif
    end
  endtask

  task automatic test_uncovered();
    int pooled[$], exp[$], got[$], lat;
    logic [0:255] t;
    pooled = {200};
    model(3, 3, 2, 2, pooled, exp);
    t = pack(pooled);
    ifc.input_data = t[0:7];
    ifc.start = 1'b1;
    @(negedge clk);
    ifc.start = 1'b0;
    lat = 0;
    while (ifc.done !== 1'b1 && lat < 200) begin @(negedge clk); lat++; end
    n_cmp++;
    if (lat !== 14) begin n_bad++; $display("FAIL uncovered_latency: got %0d required 14", lat); end
    t = '0;
    t[0:71] = ifc.output_data;
    unpack(t, 9, got);
    for (int k = 0; k < 9; k++) begin
      n_cmp++;
      if (got[k] !== exp[k]) begin
        n_bad++; $display("FAIL uncovered_pix%0d: got %0d required %0d", k, got[k], exp[k]);
      end
    end
    // Row 2 and column 2 lie outside the only window.
    n_cmp++;
    if (got[2] !== 0 || got[5] !== 0 || got[6] !== 0 || got[7] !== 0 || got[8] !== 0) begin
      n_bad++; $display("FAIL uncovered_zero: got %0d %0d %0d %0d %0d required all 0",
                        got[2], got[5], got[6], got[7], got[8]);
    end
  endtask

  initial begin
    test_reset();
    test_overlap();
    test_random();
    test_max();
    test_control();
    test_back_to_back();
    test_reset_mid();
    test_nonoverlap();
    test_uncovered();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
